ssd_mux: RTL

Multiplexed, parametrised seven-segment display driver for the board's multi-digit hex display, sitting between the processor's debug/value bus and the FPGA anode/segment pins. It captures a packed multi-nibble value on a load strobe, scans the digits at a programmable refresh rate with an anti-ghosting guard interval, and swaps in new data only at frame boundaries so a frame never shows a mix of old and new digits. Optional leading-zero blanking is compiled in by macro.

---
 rtl/ssd_pkg.sv | 22 ++
 rtl/ssd_hex_decode.sv | 11 +
 rtl/ssd_mux.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared constants for the multiplexed seven-segment driver: glyph table,
// blank pattern, digit limit and prescaler width helper.
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF    = 7'h7F;
    localparam int   MAX_DIGITS = 8;

    // Active-low {g,f,e,d,c,b,a} hex glyphs, indexed by nibble value
    localparam seg_t GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int cnt_width(input int refresh_div);
        return (refresh_div > 1) ? $clog2(refresh_div) : 1;
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble to active-low seven-segment lookup.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = GLYPH[nibble];

endmodule

// File: rtl/ssd_mux.sv
// Multiplexed seven-segment scanner with frame-aligned data swap and guard
// interval. Define SSD_LZB_EN to compile in leading-zero blanking.
module ssd_mux
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,       // legal 1..MAX_DIGITS
    parameter int REFRESH_DIV  = 100000,  // must exceed GUARD_CYCLES
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_start
);

    localparam int CNT_W  = cnt_width(REFRESH_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DATA_W = 5 * NUM_DIGITS;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    wrap;

    // Data words are packed {value, blank_mask}
    logic [DATA_W-1:0]       pending;
    logic                    pend_flag;
    logic [DATA_W-1:0]       shadow;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_mask;
    logic [NUM_DIGITS-1:0]   blank_vec;

    logic [3:0]              cur_nibble;
    seg_t                    dec_seg;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    lit;

    assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                idx <= wrap ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // load is a one-cycle strobe with no back-pressure: every cycle it is
    // high is a capture. On the wrap cycle it bypasses pending entirely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            pend_flag <= 1'b0;
            shadow    <= '0;
        end else if (wrap) begin
            if (load) begin
                shadow <= {value, blank_mask};
            end else if (pend_flag) begin
                shadow <= pending;
            end
            pend_flag <= 1'b0;
        end else if (load) begin
            pending   <= {value, blank_mask};
            pend_flag <= 1'b1;
        end
    end

    assign shadow_value = shadow[DATA_W-1:NUM_DIGITS];
    assign shadow_mask  = shadow[NUM_DIGITS-1:0];

`ifdef SSD_LZB_EN
    logic [NUM_DIGITS-1:0] lz_blank;

    // Digit i>0 goes dark when it and every digit above it are zero
    always_comb begin
        lz_blank = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz_blank[i] = ((shadow_value >> (4 * i)) == '0);
        end
    end

    assign blank_vec = shadow_mask | lz_blank;
`else
    assign blank_vec = shadow_mask;
`endif

    assign cur_nibble = shadow_value[{idx, 2'b00} +: 4];
    assign onehot     = NUM_DIGITS'(1) << idx;
    assign lit        = (cnt >= CNT_W'(GUARD_CYCLES)) && !blank_vec[idx];

    ssd_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an          <= '1;
            seg         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (lit) begin
                an  <= ~onehot;
                seg <= dec_seg;
            end else begin
                an  <= '1;
                seg <= SEG_OFF;
            end
        end
    end

endmodule
